keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  Scans a 4x4 matrix keypad and debounces key presses, driving one column low at a time.
//  Sits directly upstream of key_decode and feeds it one-hot row r[3:0] and column c[3:0].
//  Emits a one-cycle key_valid strobe per debounced press, so downstream logic registers each key once.
//  Ignores additional keys while one is held; rearms only after a debounced release.
// PARAMETERS
//  SCAN_DIV        4800    clk cycles each column is driven before rows are sampled (>=2)
//  DEBOUNCE_CYCLES 240000  consecutive stable cycles required to accept a press or release (>=2)
// PORTS
//  clk       input   1  system clock; single clock domain
//  reset_n   input   1  asynchronous, active-low reset
//  rows_n    input   4  keypad rows, active-low (pulled up), asynchronous to clk
//  cols_n    output  4  keypad column drive, active-low, exactly one bit low at all times
//  r         output  4  one-hot row of last accepted key (to key_decode)
//  c         output  4  one-hot column of last accepted key (to key_decode)
//  key_valid output  1  one-cycle pulse when a press is accepted
//  key_held  output  1  high from accepted press until accepted release
// BEHAVIOUR
//  Reset (async assert, sync release): state=SCAN, col_idx=0, cols_n=4'b1110, r=c=4'b0000,
//   key_valid=0, key_held=0, counters=0, row synchronizer flops=4'b1111.
//  rows_n passes through a 2-flop synchronizer (reset 1111); all row decisions use the synced value rs_n.
//  cols_n = ~(4'b0001 << col_idx) in every state; col_idx changes only in SCAN and on release.
//  States:
//   SCAN: div counter counts 0..SCAN_DIV-1. At count SCAN_DIV-1, sample rs_n:
//    - No row low: col_idx <= col_idx+1, wrapping 3->0. Counter returns to 0.
//    - Any row low: capture the lowest-index low row as row_idx (priority row0 highest).
//      Keep col_idx, clear the debounce counter, go to DEBOUNCE.
//   DEBOUNCE: while rs_n[row_idx]==0, the counter increments.
//    - If rs_n[row_idx] goes 1 first: return to SCAN with the same col_idx and div counter=0, no outputs.
//    - When the counter reaches DEBOUNCE_CYCLES-1 with the row still low, set r=1<<row_idx and
//      c=1<<col_idx, pulse key_valid for exactly 1 cycle, set key_held=1, and go to HELD.
//      All these updates are registered and take effect on the same edge.
//   HELD: columns stay frozen. Other rows or keys are ignored.
//    - rs_n[row_idx]==1: clear the counter and go to RELEASE.
//   RELEASE: counter increments while rs_n[row_idx]==1.
//    - If the row goes low again: return to HELD with no new key_valid.
//    - When the counter reaches DEBOUNCE_CYCLES-1: key_held=0, col_idx <= col_idx+1 (wrap), go to SCAN.
//  r and c hold the last accepted key after release. They change only on a new accepted press.
//  Press latency: at most 4*SCAN_DIV + DEBOUNCE_CYCLES + 2 (sync) cycles from a stable press to key_valid.
//  Multiple simultaneous keys in one column: the lowest row wins.
//  Keys in other columns are invisible until scanned.
//  Counters are sized $clog2(param) bits and never wrap past their terminal values.
//  Illegal or unreachable state encodings recover to SCAN.
//  Reset asserted mid-operation in any state returns all outputs to their reset values immediately,
//   with no key_valid emitted.
// TESTING (bench params SCAN_DIV=4, DEBOUNCE_CYCLES=8)
//  1. Assert reset_n=0, rows_n=1111 -> cols_n=1110, r=c=0000, key_valid=0, key_held=0.
//     Release reset -> cols_n steps 1110->1101->1011->0111->1110, every 4 cycles.
//  2. Clean press of row1/col2: rows_n=1101 whenever cols_n=1011 -> cols_n freezes at 1011,
//     one key_valid pulse, r=0010, c=0100, key_held=1. key_decode then yields 4'h6.
//  3. Bounce: row0 low for 5 cycles during column 0 -> no key_valid, key_held=0, scanning resumes at column 0.
//  4. Hold row3/col1 for 200 cycles while also pressing row0/col1 -> exactly one key_valid, with r=1000, c=0010.
//  5. Release with a 3-cycle high glitch, then low, then a clean high -> key_held stays 1 through
//     the glitch and falls 8 cycles after the clean release. cols_n then advances to 1011. r and c are held.
//  6. Assert reset_n=0 during HELD and during DEBOUNCE -> outputs go to reset values asynchronously,
//     with no key_valid after reset_n returns high.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces the
// first row seen low, and reports one key_valid strobe per accepted press.
module keypad_scan #(
  parameter int SCAN_DIV        = 4800,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [3:0] r,
  output logic [3:0] c,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        col_q, col_d, row_q, row_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DB_W-1:0]   db_q, db_d;
  logic [3:0]        r_q, r_d, c_q, c_d;
  logic              kv_q, kv_d, held_q, held_d;
  logic [3:0]        rs1_q, rs_q;

  logic       row_low, any_low, div_done, db_done;
  logic [1:0] low_idx;

  assign row_low  = ~rs_q[row_q];
  assign any_low  = ~&rs_q;
  assign div_done = (div_q == DIV_LAST);
  assign db_done  = (db_q == DB_LAST);

  // Row 0 has priority when several rows in the driven column are low.
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!rs_q[i]) low_idx = 2'(i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      div_q   <= '0;
      db_q    <= '0;
      r_q     <= 4'b0000;
      c_q     <= 4'b0000;
      kv_q    <= 1'b0;
      held_q  <= 1'b0;
      rs1_q   <= 4'b1111;
      rs_q    <= 4'b1111;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      div_q   <= div_d;
      db_q    <= db_d;
      r_q     <= r_d;
      c_q     <= c_d;
      kv_q    <= kv_d;
      held_q  <= held_d;
      rs1_q   <= rows_n;
      rs_q    <= rs1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:     if (div_done && any_low) state_d = DEBOUNCE;
      DEBOUNCE: if (!row_low) state_d = SCAN;
                else if (db_done) state_d = HELD;
      HELD:     if (!row_low) state_d = RELEASE;
      RELEASE:  if (row_low) state_d = HELD;
                else if (db_done) state_d = SCAN;
      default:  state_d = SCAN;
    endcase
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    div_d  = div_q;
    db_d   = db_q;
    r_d    = r_q;
    c_d    = c_q;
    kv_d   = 1'b0;
    held_d = held_q;
    case (state_q)
      SCAN: begin
        if (div_done) begin
          div_d = '0;
          if (any_low) begin
            row_d = low_idx;
            db_d  = '0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DEBOUNCE: begin
        if (!row_low) begin
          div_d = '0;
        end else if (db_done) begin
          r_d    = 4'b0001 << row_q;
          c_d    = 4'b0001 << col_q;
          kv_d   = 1'b1;
          held_d = 1'b1;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      HELD: if (!row_low) db_d = '0;
      RELEASE: begin
        if (!row_low) begin
          if (db_done) begin
            held_d = 1'b0;
            col_d  = col_q + 2'd1;
            div_d  = '0;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end
      end
      default: div_d = '0;
    endcase
  end

  assign cols_n    = ~(4'b0001 << col_q);
  assign r         = r_q;
  assign c         = c_q;
  assign key_valid = kv_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CYCLES=8 and a
// behavioural 4x4 key matrix wired between cols_n and rows_n.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] rows_n, cols_n, r, c;
  logic       key_valid, key_held;
  logic [3:0] keys [4];
  int n_chk = 0, n_fail = 0, kv_cnt = 0;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .rows_n(rows_n), .cols_n(cols_n),
    .r(r), .c(c), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; a row reads low only while that column is driven.
  always_comb begin
    for (int i = 0; i < 4; i++) rows_n[i] = ~|(keys[i] & ~cols_n);
  end

  always @(negedge clk) if (key_valid) kv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_kv(input string tag, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_unheld(input string tag, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (!key_held) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  function automatic int oh2i(input logic [3:0] v);
    int idx = -1;
    for (int i = 0; i < 4; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cols"}, 32'(cols_n), 32'hE);
    chk({tag, "_r"},    32'(r), 32'h0);
    chk({tag, "_c"},    32'(c), 32'h0);
    chk({tag, "_kv"},   32'(key_valid), 32'h0);
    chk({tag, "_held"}, 32'(key_held), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) keys[i] = 4'b0000;
    reset_n = 1'b0;

    // 1: reset values, then free-running column walk, 4 cycles per column
    tick(3);
    chk_reset_vals("t1_rst");
    reset_n = 1'b1;
    tick(3);  chk("t1_col0_end", 32'(cols_n), 32'hE);
    tick(1);  chk("t1_col1", 32'(cols_n), 32'hD);
    tick(4);  chk("t1_col2", 32'(cols_n), 32'hB);
    tick(4);  chk("t1_col3", 32'(cols_n), 32'h7);
    tick(4);  chk("t1_wrap", 32'(cols_n), 32'hE);

    // 3: row0/col0 low for 5 cycles; seen at the column-0 sample but dropped before debounce completes
    keys[0][0] = 1'b1;
    tick(5);
    keys[0][0] = 1'b0;
    // 2 sync flops delay the release, so DEBOUNCE exits 3 edges later; scan restarts the column with div=0
    tick(6);
    chk("t3_same_col", 32'(cols_n), 32'hE);
    chk("t3_no_held", 32'(key_held), 32'h0);
    chk("t3_no_kv", 32'(kv_cnt), 32'd0);
    tick(1);
    chk("t3_resume", 32'(cols_n), 32'hD);

    // 2: clean press row1/col2
    keys[1][2] = 1'b1;
    wait_kv("t2_kv_seen", 100);
    chk("t2_cols_frozen", 32'(cols_n), 32'hB);
    chk("t2_r", 32'(r), 32'h2);
    chk("t2_c", 32'(c), 32'h4);
    chk("t2_held", 32'(key_held), 32'h1);
    chk("t2_decode", 32'(oh2i(r) * 4 + oh2i(c)), 32'h6);
    tick(1);
    chk("t2_pulse_1cyc", 32'(key_valid), 32'h0);
    chk("t2_cols_still", 32'(cols_n), 32'hB);
    keys[1][2] = 1'b0;
    wait_unheld("t2_release_seen", 50);
    chk("t2_kv_count", 32'(kv_cnt), 32'd1);
    chk("t2_r_kept", 32'(r), 32'h2);
    chk("t2_next_col", 32'(cols_n), 32'h7);

    // 4: hold row3/col1, add row0/col1 while held -> only the first key counts
    keys[3][1] = 1'b1;
    wait_kv("t4_kv_seen", 100);
    chk("t4_r", 32'(r), 32'h8);
    chk("t4_c", 32'(c), 32'h2);
    keys[0][1] = 1'b1;
    tick(200);
    chk("t4_kv_count", 32'(kv_cnt), 32'd2);
    chk("t4_held", 32'(key_held), 32'h1);
    chk("t4_r_kept", 32'(r), 32'h8);
    chk("t4_cols_frozen", 32'(cols_n), 32'hD);
    keys[0][1] = 1'b0;
    tick(5);

    // 5: 3-cycle release glitch, then clean release
    keys[3][1] = 1'b0;
    tick(3);
    keys[3][1] = 1'b1;
    tick(12);
    chk("t5_glitch_held", 32'(key_held), 32'h1);
    chk("t5_glitch_kv", 32'(kv_cnt), 32'd2);
    keys[3][1] = 1'b0;
    // 2 sync flops + 1 edge to enter RELEASE + 8 debounce cycles
    tick(10);
    chk("t5_held_before", 32'(key_held), 32'h1);
    tick(1);
    chk("t5_held_fall", 32'(key_held), 32'h0);
    chk("t5_cols_adv", 32'(cols_n), 32'hB);
    chk("t5_r_kept", 32'(r), 32'h8);
    chk("t5_c_kept", 32'(c), 32'h2);

    // 6a: reset during HELD
    keys[2][0] = 1'b1;
    wait_kv("t6_kv_seen", 100);
    tick(3);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("t6_held_rst");
    keys[2][0] = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(40);
    chk("t6_held_no_kv", 32'(kv_cnt), 32'd3);
    chk("t6_held_idle", 32'(key_held), 32'h0);

    // 6b: reset during DEBOUNCE (entered on the 4th edge, acceptance would be the 12th)
    #2 reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    keys[0][0] = 1'b1;
    tick(7);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("t6_deb_rst");
    keys[0][0] = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(40);
    chk("t6_deb_no_kv", 32'(kv_cnt), 32'd3);
    chk("t6_deb_idle", 32'(key_held), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
